rat_io_ctrl: RTL
================

RAT_IO_CTRL -- requirements
Module: rat_io_ctrl

Interface
REQ-001 Parameter DB_COUNT, default 16'd50000: debounce stability time in CLK cycles; legal range 2..65535.
REQ-002 Parameter INTR_CYCLES, default 4'd8: INTR pulse width in CLK cycles; legal range 1..15.
REQ-003 Port CLK, input, 1: the single clock; every register in the block is updated on its rising edge.
REQ-004 Port RESET, input, 1: synchronous, active-high reset, sampled on the rising CLK edge.
REQ-005 Port OUT_PORT, input, 8: write data driven by the MCU.
REQ-006 Port PORT_ID, input, 8: I/O address driven by the MCU.
REQ-007 Port IO_STRB, input, 1: MCU write strobe, one cycle wide.
REQ-008 Port SWITCHES, input, 8: asynchronous board switches.
REQ-009 Port BTN, input, 1: asynchronous, bouncing interrupt pushbutton.
REQ-010 Port IN_PORT, output, 8: read data returned to the MCU.
REQ-011 Port LEDS, output, 8: LED output register.
REQ-012 Port SSEG_VAL, output, 8: seven-segment value register.
REQ-013 Port INTR, output, 1: interrupt request to the MCU.

Function
REQ-014 The block shall write LEDS <= OUT_PORT on the edge where IO_STRB=1 and PORT_ID=8'h40.
REQ-015 The block shall write SSEG_VAL <= OUT_PORT on the edge where IO_STRB=1 and PORT_ID=8'h81.
REQ-016 On the edge where IO_STRB=1 and PORT_ID=8'h42, the block shall clear PEND; OUT_PORT data is ignored.
REQ-017 Strobes to any other PORT_ID shall have no effect; OUT_PORT and PORT_ID shall be ignored when IO_STRB=0.
REQ-018 SWITCHES shall pass through a 2-flop synchronizer to form SW_S (2-cycle latency).
REQ-019 IN_PORT shall be combinational from PORT_ID, independent of IO_STRB:
- 8'h20 -> SW_S
- 8'h21 -> {6'b0, BTN_DB, PEND}
- any other PORT_ID -> 8'h00
REQ-020 BTN shall pass through a 2-flop synchronizer to form BTN_S.
REQ-021 BTN_DB shall change to BTN_S only after BTN_S differs from BTN_DB for DB_COUNT consecutive cycles.
REQ-022 The debounce counter shall clear on any cycle where BTN_S equals BTN_DB; the counter shall saturate, never wrap.
REQ-023 The interrupt FSM shall have states IDLE, PULSE, HOLD:
- IDLE -> PULSE on a BTN_DB 0->1 transition.
- PULSE: INTR=1 for exactly INTR_CYCLES cycles, then -> HOLD.
- HOLD -> IDLE when BTN_DB=0.
- A BTN_DB 1->0->1 sequence occurring during PULSE shall not extend or restart the pulse.
REQ-024 INTR shall be registered and equal 1 only in PULSE.
REQ-025 PEND shall set on the IDLE->PULSE transition.
REQ-026 If a PEND clear strobe and a PEND set occur on the same edge, set shall win.
REQ-027 INTR shall not depend on PEND; a new button press shall interrupt again even with PEND=1.

Reset
REQ-028 On RESET=1 at a CLK edge, the block shall set LEDS=8'h00, SSEG_VAL=8'h00, INTR=0, PEND=0, BTN_DB=0, and the debounce counter=0.
REQ-029 On RESET=1 at a CLK edge, the FSM shall go to IDLE and all synchronizer flops shall go to 0.
REQ-030 RESET shall take priority over any simultaneous strobe or button event.
REQ-031 RESET asserted during PULSE shall drop INTR on the next edge, with no resumption after release.

Verification
REQ-032 The bench shall cover the following directed scenarios (sim with DB_COUNT=4, INTR_CYCLES=3):
- Write 8'hA5 to 8'h40 with IO_STRB -> LEDS=8'hA5 next cycle; SSEG_VAL unchanged at 8'h00.
- Write 8'h3C to 8'h99 with IO_STRB -> LEDS and SSEG_VAL unchanged; then SWITCHES=8'h5A, PORT_ID=8'h20 -> IN_PORT=8'h5A within 2 cycles.
- BTN high for 3 cycles, then low -> no INTR, BTN_DB stays 0; BTN held high 10 cycles -> INTR high exactly 3 cycles, PEND=1, IN_PORT at 8'h21 reads 8'h03.
- With PEND=1, strobe to 8'h42 -> PEND=0; IN_PORT at 8'h21 reads 8'h02 while the button is held.
- Clear strobe on the same edge as a new IDLE->PULSE transition -> PEND=1.
- RESET during PULSE with LEDS=8'hFF -> next edge INTR=0, LEDS=8'h00, FSM in IDLE; no INTR while BTN stays high until debounced re-press.

Source files
------------

// File: rtl/rat_io_ctrl.sv
// RAT MCU I/O controller: output port registers (LEDs, seven-segment),
// switch/button input ports, debounced pushbutton interrupt with a
// fixed-width INTR pulse and a software-clearable pending flag.
module rat_io_ctrl #(
  parameter logic [15:0] DB_COUNT    = 16'd50000,
  parameter logic [3:0]  INTR_CYCLES = 4'd8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic       BTN,
  output logic [7:0] IN_PORT,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL,
  output logic       INTR
);

  localparam logic [7:0] ID_LEDS   = 8'h40;
  localparam logic [7:0] ID_SSEG   = 8'h81;
  localparam logic [7:0] ID_CLR    = 8'h42;
  localparam logic [7:0] ID_SW     = 8'h20;
  localparam logic [7:0] ID_STATUS = 8'h21;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  logic [7:0]  sw_meta_reg;
  logic [7:0]  sw_s_reg;
  logic        btn_meta_reg;
  logic        btn_s_reg;
  logic        btn_db_reg;
  logic [15:0] db_cnt_reg;
  state_t      state_reg;
  logic [3:0]  pulse_cnt_reg;
  logic        pend_reg;

  logic db_flip;
  logic db_rise;
  logic clr_strb;

  // The debounced level flips on the DB_COUNT-th consecutive disagreeing
  // cycle; the FSM sees the rising flip on the same edge it is registered.
  assign db_flip  = (btn_s_reg != btn_db_reg) && (db_cnt_reg == DB_COUNT - 16'd1);
  assign db_rise  = db_flip && btn_s_reg;
  assign clr_strb = IO_STRB && (PORT_ID == ID_CLR);

  // Two-flop synchronizers for the asynchronous switches and button
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta_reg  <= 8'h00;
      sw_s_reg     <= 8'h00;
      btn_meta_reg <= 1'b0;
      btn_s_reg    <= 1'b0;
    end else begin
      sw_meta_reg  <= SWITCHES;
      sw_s_reg     <= sw_meta_reg;
      btn_meta_reg <= BTN;
      btn_s_reg    <= btn_meta_reg;
    end
  end

  // Debounce: count consecutive disagreeing cycles, saturating, clear on agreement
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_db_reg <= 1'b0;
      db_cnt_reg <= 16'd0;
    end else if (btn_s_reg == btn_db_reg) begin
      db_cnt_reg <= 16'd0;
    end else if (db_flip) begin
      btn_db_reg <= btn_s_reg;
      db_cnt_reg <= 16'd0;
    end else if (db_cnt_reg != 16'hFFFF) begin
      db_cnt_reg <= db_cnt_reg + 16'd1;
    end
  end

  // Interrupt FSM with registered INTR and the pending flag (set beats clear)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      INTR          <= 1'b0;
      pulse_cnt_reg <= 4'd0;
      pend_reg      <= 1'b0;
    end else begin
      if (clr_strb) begin
        pend_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (db_rise) begin
            state_reg     <= PULSE;
            INTR          <= 1'b1;
            pulse_cnt_reg <= 4'd1;
            pend_reg      <= 1'b1;
          end
        end
        PULSE: begin
          // Button activity is ignored here so the pulse is never stretched
          if (pulse_cnt_reg == INTR_CYCLES) begin
            state_reg <= HOLD;
            INTR      <= 1'b0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 4'd1;
          end
        end
        HOLD: begin
          if (!btn_db_reg) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          INTR      <= 1'b0;
        end
      endcase
    end
  end

  // MCU output port registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS     <= 8'h00;
      SSEG_VAL <= 8'h00;
    end else if (IO_STRB) begin
      if (PORT_ID == ID_LEDS) begin
        LEDS <= OUT_PORT;
      end
      if (PORT_ID == ID_SSEG) begin
        SSEG_VAL <= OUT_PORT;
      end
    end
  end

  // Read mux, decoded from PORT_ID alone
  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      ID_SW:     IN_PORT = sw_s_reg;
      ID_STATUS: IN_PORT = {6'b0, btn_db_reg, pend_reg};
      default:   IN_PORT = 8'h00;
    endcase
  end

endmodule
